// File: rtl/dm_arbiter.sv
// Round-robin arbiter giving two requesters one single-port data memory with byte-lane merge writes.
// Ack follows the grant by one cycle and the grant waits while an access is in ACK; requests stay held until acked.
module dm_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [3:0]    be0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [3:0]    be1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-3:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic          gnt_vld;
  logic          gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [3:0]    sel_be;
  logic [DW-1:0] sel_wdata;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{addr0[1:0], addr1[1:0]};

  // Reset gates the grant so the memory never sees a write while reset is high.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    gnt_vld   = 1'b0;
    gnt       = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && (req0 || req1)) begin
          gnt_vld   = 1'b1;
          gnt       = (req0 && req1) ? ~last : req1;
          state_nxt = ACK;
          last_nxt  = gnt;
        end
      end
      ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_we    = gnt ? we1    : we0;
    sel_addr  = gnt ? addr1  : addr0;
    sel_be    = gnt ? be1    : be0;
    sel_wdata = gnt ? wdata1 : wdata0;
  end

  // Read data is combinational, so the lane merge and the write happen in the grant cycle.
  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    if (gnt_vld) begin
      mem_addr = sel_addr[AW-1:2];
      if (sel_we) begin
        mem_we = |sel_be;
        for (int i = 0; i < 4; i++) begin
          mem_wd[8*i +: 8] = sel_be[i] ? sel_wdata[8*i +: 8] : mem_rd[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      last   <= 1'b1;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      ack0  <= gnt_vld && !gnt;
      ack1  <= gnt_vld && gnt;
      if (gnt_vld && !gnt) rdata0 <= mem_rd;
      if (gnt_vld && gnt)  rdata1 <= mem_rd;
    end
  end

  assign busy = (state == ACK);

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: behavioural memory, reference word model and an ack-driven scoreboard.
module tb_dm_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [11:0] addr0, addr1;
  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] ref_mem [int];
  logic [31:0] mem [1024] = '{default: 32'h0};

  dm_arbiter #(.AW(12), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .be0(be0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .be1(be1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  // Every ack retires the oldest expected completion.
  always begin
    @(posedge clk);
    #1;
    if (ack0 || ack1) begin
      if (sb.size() == 0) chk("unexpected_ack", 32'({ack1, ack0}), 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_port", 32'(ack1), 32'(e.port));
        chk("sb_rdata", e.port ? rdata1 : rdata0, e.data);
      end
    end
  end

  task automatic issue(input logic p, input logic w, input logic [11:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    logic [31:0] old, merged;
    logic        exp_we;
    @(negedge clk);
    old    = ref_rd(int'(a[11:2]));
    merged = old;
    for (int i = 0; i < 4; i++) if (b[i]) merged[8*i +: 8] = d[8*i +: 8];
    exp_we = w && (b != 4'b0000);
    if (exp_we) ref_mem[int'(a[11:2])] = merged;
    sb.push_back('{p, old});
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; be1 = b; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; be0 = b; wdata0 = d; end
    #1;
    chk("grant_addr", 32'(mem_addr), 32'(a[11:2]));
    chk("grant_we", 32'(mem_we), 32'(exp_we));
    if (exp_we) chk("grant_wd", mem_wd, merged);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
    chk("ack_busy", 32'(busy), 32'd1);
    chk("ack_mem_we", 32'(mem_we), 32'd0);
    chk("ack_port", 32'(p ? ack1 : ack0), 32'd1);
    chk("ack_other", 32'(p ? ack0 : ack1), 32'd0);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_acks", 32'({ack1, ack0}), 32'd0);
  endtask

  task automatic access(input logic p, input logic w, input logic [11:0] a,
                        input logic [3:0] b, input logic [31:0] d);
    issue(p, w, a, b, d);
    idle();
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; be0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; be1 = '0; wdata1 = '0;

    // Reset values, with a write presented while reset is high.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acks", 32'({ack1, ack0}), 32'd0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h0F0; be0 = 4'hF; wdata0 = 32'hFFFF_FFFF;
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Full write then read back.
    access(0, 1, 12'h010, 4'hF, 32'h1234_5678);
    access(0, 0, 12'h010, 4'h0, 32'h0);
    chk("rd_full_const", rdata0, 32'h1234_5678);

    // Byte-lane merge across ports.
    access(0, 1, 12'h020, 4'hF, 32'hAABB_CCDD);
    access(1, 1, 12'h020, 4'b0010, 32'h0000_1100);
    access(0, 0, 12'h020, 4'h0, 32'h0);
    chk("rd_merge_const", rdata0, 32'hAABB_11DD);

    // Empty strobe: acked, no memory write, pre-write word returned.
    access(1, 1, 12'h010, 4'b0000, 32'hFFFF_FFFF);
    chk("be0_rdata", rdata1, 32'h1234_5678);
    access(1, 0, 12'h010, 4'h0, 32'h0);

    // rdata1 held through a port 0 access.
    access(1, 1, 12'h040, 4'hF, 32'h0000_0005);
    access(1, 0, 12'h040, 4'h0, 32'h0);
    access(0, 0, 12'h044, 4'h0, 32'h0);
    chk("rdata1_hold", rdata1, 32'h0000_0005);
    chk("rdata0_044", rdata0, 32'h0);

    // Reset during ACK.
    issue(0, 0, 12'h020, 4'h0, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rack_acks", 32'({ack1, ack0}), 32'd0);
    chk("rack_busy", 32'(busy), 32'd0);
    chk("rack_rdata0", rdata0, 32'h0);
    chk("rack_rdata1", rdata1, 32'h0);
    chk("rack_mem_we", 32'(mem_we), 32'd0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h100; be0 = 4'hF; wdata0 = 32'hDEAD_BEEF;
    #1;
    chk("rack_force_we", 32'(mem_we), 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle();
    idle();
    access(0, 0, 12'h010, 4'h0, 32'h0);
    access(1, 0, 12'h100, 4'h0, 32'h0);

    // Both requesting from reset: grants alternate starting with port 0.
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h020;
    #1;
    chk("fair_rst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{1'b0, ref_rd(int'(addr0[11:2]))});
      sb.push_back('{1'b1, ref_rd(int'(addr1[11:2]))});
    end
    reset = 1'b0;
    #1;
    chk("fair_c1_addr", 32'(mem_addr), 32'(addr0[11:2]));
    chk("fair_c1_acks", 32'({ack1, ack0}), 32'd0);
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk);
      #1;
      chk("fair_ack0", 32'(ack0), 32'((k == 2) || (k == 6)));
      chk("fair_ack1", 32'(ack1), 32'((k == 4) || (k == 8)));
      if (busy) chk("fair_ack_we", 32'(mem_we), 32'd0);
      if (k == 8) begin req0 = 1'b0; req1 = 1'b0; end
    end
    idle();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
